// File: rtl/shift_add_mult_n.sv
// ---------------------------------------------------------------------------
// shift_add_mult_n
// Sequential WIDTH x WIDTH shift-and-add multiplier. Signed (two's
// complement) or unsigned operands, one iteration per clock, and a
// start/busy/done handshake.
//
// Ports:
//   CLK         clock, rising edge
//   RST         synchronous active-high reset
//   STRT        start request, accepted only while not busy
//   SGN         operand mode captured with STRT (1 = signed)
//   multicand   multiplicand captured with STRT
//   multiplier  multiplier captured with STRT
//   P           registered 2*WIDTH product, held between operations
//   BUSY        high while iterations are running
//   DONE        one-cycle pulse when a new P is valid
// ---------------------------------------------------------------------------
module shift_add_mult_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 STRT,
  input  logic                 SGN,
  input  logic [WIDTH-1:0]     multicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   P,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned AW    = WIDTH + 1;   // accumulator width
  localparam int unsigned SW    = WIDTH + 2;   // accumulator add incl. carry-out

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    m_q, m_d;
  logic [AW-1:0]       a_q, a_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic [2*WIDTH-1:0]  p_q, p_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Datapath for one iteration
  logic [AW-1:0]       mx;
  logic [AW-1:0]       addend;
  logic                last;
  logic                sub;
  logic [SW-1:0]       sum_ext;
  logic                msb_in;
  logic [AW-1:0]       a_nx;
  logic [WIDTH-1:0]    q_nx;

  always_comb begin
    mx     = mode_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
    last   = (cnt_q == CNT_W'(1));
    // Multiplier MSB has negative weight in signed mode: subtract on last step
    sub    = mode_q && last;
    addend = sub ? ~mx : mx;
    if (q_q[0]) begin
      sum_ext = {1'b0, a_q} + {1'b0, addend} + {{(SW-1){1'b0}}, sub};
    end else begin
      sum_ext = {1'b0, a_q};
    end
    // Arithmetic shift in signed mode, carry shift in unsigned mode
    msb_in = mode_q ? sum_ext[AW-1] : sum_ext[AW];
    a_nx   = {msb_in, sum_ext[AW-1:1]};
    q_nx   = {sum_ext[0], q_q[WIDTH-1:1]};
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    p_d     = p_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        if (STRT) begin
          m_d     = multicand;
          q_d     = multiplier;
          a_d     = '0;
          cnt_d   = CNT_W'(WIDTH);
          mode_d  = SGN;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d   = a_nx;
        q_d   = q_nx;
        cnt_d = cnt_q - CNT_W'(1);
        if (last) begin
          p_d     = {a_nx[WIDTH-1:0], q_nx};
          state_d = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign P    = p_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_shift_add_mult_n.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mult_n
// Scoreboard bench for shift_add_mult_n with a 4-bit and an 8-bit instance.
// Drivers push the expected product and DONE edge on each accepted start;
// per-instance monitors pop and compare whenever DONE is seen.
// ---------------------------------------------------------------------------
module tb_shift_add_mult_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;

  logic        strt4 = 1'b0, sgn4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  p4;
  logic        busy4, done4;

  logic        strt8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic        busy8, done8;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  exp_p4[$];
  int unsigned exp_e4[$];
  logic [15:0] exp_p8[$];
  int unsigned exp_e8[$];

  shift_add_mult_n #(.WIDTH(4)) u_dut4 (
    .CLK(clk), .RST(rst), .STRT(strt4), .SGN(sgn4),
    .multicand(a4), .multiplier(b4), .P(p4), .BUSY(busy4), .DONE(done4)
  );

  shift_add_mult_n #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RST(rst), .STRT(strt8), .SGN(sgn8),
    .multicand(a8), .multiplier(b8), .P(p8), .BUSY(busy8), .DONE(done8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Reference products from plain integer arithmetic
  function automatic logic [7:0] ref4(input logic s, input logic [3:0] a, input logic [3:0] b);
    longint x, y;
    if (s) begin x = $signed(a); y = $signed(b); end
    else   begin x = a;          y = b;          end
    return 8'(x * y);
  endfunction

  function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
    longint x, y;
    if (s) begin x = $signed(a); y = $signed(b); end
    else   begin x = a;          y = b;          end
    return 16'(x * y);
  endfunction

  // Monitors: compare product and DONE timing against the scoreboard
  always @(negedge clk) begin
    if (!rst && done4) begin
      if (exp_p4.size() == 0) begin
        chk("dut4_unexpected_done", 32'(done4), 32'(0));
      end else begin
        chk("dut4_product", 32'(p4), 32'(exp_p4.pop_front()));
        chk("dut4_done_edge", cyc, exp_e4.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (exp_p8.size() == 0) begin
        chk("dut8_unexpected_done", 32'(done8), 32'(0));
      end else begin
        chk("dut8_product", 32'(p8), 32'(exp_p8.pop_front()));
        chk("dut8_done_edge", cyc, exp_e8.pop_front());
      end
    end
  end

  // Called at a negedge; accept happens at the following posedge
  task automatic start4(input logic s, input logic [3:0] a, input logic [3:0] b);
    sgn4 = s; a4 = a; b4 = b; strt4 = 1'b1;
    exp_p4.push_back(ref4(s, a, b));
    exp_e4.push_back(cyc + 1 + 4);
    @(negedge clk);
    strt4 = 1'b0;
  endtask

  task automatic start8(input logic s, input logic [7:0] a, input logic [7:0] b);
    sgn8 = s; a8 = a; b8 = b; strt8 = 1'b1;
    exp_p8.push_back(ref8(s, a, b));
    exp_e8.push_back(cyc + 1 + 8);
    @(negedge clk);
    strt8 = 1'b0;
  endtask

  task automatic wait_done4();
    for (int i = 0; i < 20; i++) begin
      if (done4) return;
      @(negedge clk);
    end
    chk("dut4_done_timeout", 32'(0), 32'(1));
  endtask

  // Waits for DONE while occasionally firing STRT with junk operands mid-run
  task automatic wait_done8();
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        strt8 = 1'b0;
        return;
      end
      if (busy8 && $urandom_range(0, 5) == 0) begin
        strt8 = 1'b1;
        sgn8  = 1'($urandom);
        a8    = 8'($urandom);
        b8    = 8'($urandom);
      end else begin
        strt8 = 1'b0;
      end
      @(negedge clk);
    end
    strt8 = 1'b0;
    chk("dut8_done_timeout", 32'(0), 32'(1));
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'h80;
      2:       return 8'h7F;
      3:       return 8'hFF;
      4:       return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int busy_cnt;
    int done_cnt;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_p4", 32'(p4), 32'(0));
    chk("reset_busy4", 32'(busy4), 32'(0));
    chk("reset_done4", 32'(done4), 32'(0));
    chk("reset_p8", 32'(p8), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // 15x15 unsigned: BUSY for 4 cycles, single-cycle DONE
    start4(1'b0, 4'hF, 4'hF);
    busy_cnt = 0;
    while (busy4 && busy_cnt < 20) begin
      busy_cnt++;
      @(negedge clk);
    end
    chk("t1_busy_cycles", 32'(busy_cnt), 32'(4));
    chk("t1_done", 32'(done4), 32'(1));
    chk("t1_p", 32'(p4), 32'(8'hE1));
    @(negedge clk);
    chk("t1_done_pulse", 32'(done4), 32'(0));
    chk("t1_p_hold", 32'(p4), 32'(8'hE1));

    // Signed cases
    start4(1'b1, 4'b1101, 4'b0101); wait_done4();
    chk("t2_m3x5", 32'(p4), 32'(8'hF1));
    @(negedge clk);
    start4(1'b1, 4'b1000, 4'b1000); wait_done4();
    chk("t2_m8xm8", 32'(p4), 32'(8'h40));
    @(negedge clk);
    start4(1'b1, 4'b0111, 4'b1111); wait_done4();
    chk("t2_7xm1", 32'(p4), 32'(8'hF9));
    @(negedge clk);

    // Back-to-back start in the DONE cycle; P holds old result meanwhile
    start4(1'b0, 4'h7, 4'hD); wait_done4();
    chk("t3_first", 32'(p4), 32'(8'h5B));
    start4(1'b0, 4'h9, 4'h0);
    chk("t3_busy_again", 32'(busy4), 32'(1));
    chk("t3_p_hold", 32'(p4), 32'(8'h5B));
    wait_done4();
    chk("t3_second", 32'(p4), 32'(8'h00));
    @(negedge clk);

    // STRT during RUN is ignored
    start4(1'b0, 4'hF, 4'hF);
    @(negedge clk);
    strt4 = 1'b1; sgn4 = 1'b1; a4 = 4'h3; b4 = 4'h3;
    @(negedge clk);
    strt4 = 1'b0;
    wait_done4();
    chk("t4_ignored", 32'(p4), 32'(8'hE1));
    @(negedge clk);

    // Reset mid-run
    start4(1'b0, 4'hF, 4'hF);
    @(negedge clk);
    rst = 1'b1;
    exp_p4.delete();
    exp_e4.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", 32'(busy4), 32'(0));
    chk("t5_done", 32'(done4), 32'(0));
    chk("t5_p", 32'(p4), 32'(0));
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) done_cnt++;
    end
    chk("t5_no_done", 32'(done_cnt), 32'(0));
    start4(1'b0, 4'h3, 4'h5); wait_done4();
    chk("t5_fresh", 32'(p4), 32'(8'h0F));
    @(negedge clk);

    // Random 8-bit sweep with gaps, back-to-back starts and ignored STRTs
    for (int k = 0; k < 1200; k++) begin
      start8(1'($urandom), pick8(), pick8());
      wait_done8();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    chk("dut4_queue_empty", 32'(exp_p4.size()), 32'(0));
    chk("dut8_queue_empty", 32'(exp_p8.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_add_mult_n.md
Name: shift_add_mult_n

Overview:
Parametrised sequential shift-and-add multiplier. It replaces the fixed 4x4 unsigned datapath with a WIDTH x WIDTH unit that supports both signed and unsigned operands. It has a start/busy/done handshake and a registered product output. It sits beside the operand load registers and is started by the control FSM through STRT.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
STRT  input  1  start request; sampled only while BUSY=0.
SGN  input  1  operand mode, sampled with STRT: 1 = two's complement signed, 0 = unsigned.
multicand  input  WIDTH  multiplicand, sampled with STRT.
multiplier  input  WIDTH  multiplier, sampled with STRT.
P  output  2*WIDTH  registered product; holds its value between operations.
BUSY  output  1  high while an operation is in progress.
DONE  output  1  single-cycle pulse in the cycle a new P is valid.

Behaviour:
- Reset (RST=1 at a rising edge):
  - state goes to IDLE.
  - P=0, BUSY=0, DONE=0.
  - internal M, A, Q and count registers are cleared.
  - Reset overrides every other input, including during RUN; no partial result ever appears on P.
- Internal registers:
  - M: WIDTH, latched multiplicand.
  - A: WIDTH+1 accumulator (extra bit holds the carry in unsigned mode and the sign in signed mode).
  - Q: WIDTH, multiplier being shifted out.
  - cnt: ceil(log2(WIDTH+1)) bits.
  - mode: 1 bit, latched SGN.
- States: IDLE, RUN, FIN.
- IDLE or FIN with STRT=1 (accept):
  - M<=multicand, Q<=multiplier, A<=0, cnt<=WIDTH, mode<=SGN.
  - go to RUN; BUSY=1 from the next cycle.
- IDLE with STRT=0: stay in IDLE.
- FIN with STRT=0: go to IDLE.
- RUN iteration, one per cycle:
  - Let Mx = M extended to WIDTH+1 bits (sign-extended if mode=1, zero-extended otherwise).
  - If Q[0]=1: sum = A + Mx, except when mode=1 and cnt==1, where sum = A - Mx (the multiplier MSB carries negative weight).
  - If Q[0]=0: sum = A.
  - {A,Q} <= {sum,Q} shifted right by 1. The shifted-in MSB is sum[WIDTH] when mode=1; in unsigned mode it is the carry out of the WIDTH+1-bit add.
  - cnt <= cnt-1.
- Completion: when cnt==1 in RUN, that final iteration also:
  - loads P with the final {A[WIDTH-1:0],Q}.
  - moves state to FIN.
- Outputs by state:
  - FIN: DONE=1, BUSY=0.
  - RUN: BUSY=1, DONE=0.
  - IDLE: both 0.
- Latency: if STRT is accepted at edge 0, the iterations happen at edges 1..WIDTH, and P/DONE are valid in the cycle after edge WIDTH. Total WIDTH+1 edges from accept to result.
- Back-to-back: STRT=1 during the DONE cycle starts the next operation immediately. P keeps the old result until the new completion.
- STRT while BUSY=1 is ignored; it is neither queued nor allowed to corrupt operands.
- Operand inputs and SGN are don't-care outside the accept edge.
- Width rules:
  - Unsigned: the maximum product (2^W-1)^2 fits in 2W bits.
  - Signed: the extreme case (-2^(W-1))^2 = 2^(2W-2) fits in a 2W two's complement value.
  - No overflow flag is required.

Test Plan:
1. WIDTH=4, SGN=0, 15x15, STRT one cycle → BUSY high 4 cycles; DONE pulses 5 edges after accept; P=0xE1 (225).
2. WIDTH=4, SGN=1, multicand=4'b1101 (-3), multiplier=4'b0101 (5) → P=8'hF1 (-15). Repeat with -8 x -8 → P=8'h40 (64). Repeat with 7 x -1 → P=8'hF9.
3. WIDTH=4, SGN=0, 7x13, then STRT=1 again during the DONE cycle with 0x9 → P=0x5B, DONE; then P=0x00 after the next DONE, with P holding 0x5B in between.
4. Start 15x15, pulse STRT with different operands at RUN cycle 2 → ignored; result still 0xE1 at the original DONE time.
5. Start 15x15, assert RST at RUN cycle 2 → the next cycle has BUSY=0, DONE=0, P=0; no DONE follows; a fresh 3x5 start afterwards gives P=0x0F.
6. WIDTH=8, random signed and unsigned sweep (≥1000 ops) against a reference model → P matches and DONE latency is exactly 9 edges for every operation.
